// File: rtl/conv_window_buffer.sv
// Multi-channel NxN sliding-window buffer.
// A raster-order pixel stream (all channels in parallel) is written into
// N-1 line buffers per channel. A small shift register assembles the window,
// and complete windows are emitted at the configured stride over a
// valid/ready handshake. Frames may follow each other with no gap.
module conv_window_buffer #(
    parameter int N           = 3,
    parameter int BitSize     = 4,
    parameter int ImageWidth  = 4,
    parameter int ImageHeight = 4,
    parameter int Channels    = 1,
    parameter int Stride      = 1
) (
    input  logic                                             clk,
    input  logic                                             res_n,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [Channels-1:0][BitSize-1:0]                 in_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [Channels-1:0][N-1:0][N-1:0][BitSize-1:0]   out_data,
    output logic                                             out_last,
    output logic                                             out_done
);

    localparam int ColW = (ImageWidth  > 1) ? $clog2(ImageWidth)  : 1;
    localparam int RowW = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
    localparam logic [ColW-1:0] ColMax = ColW'(ImageWidth - 1);
    localparam logic [RowW-1:0] RowMax = RowW'(ImageHeight - 1);

    // Position of the pixel that completes the final stride-aligned window.
    localparam int LastRow = ((ImageHeight - N) / Stride) * Stride + N - 1;
    localparam int LastCol = ((ImageWidth  - N) / Stride) * Stride + N - 1;

    typedef logic [Channels-1:0][N-1:0][N-1:0][BitSize-1:0] window_t;
    typedef logic [Channels-1:0][N-1:0][BitSize-1:0]         column_t;

    logic [ColW-1:0]     col;
    logic [RowW-1:0]     row;

    // line_mem[ch][k][x] holds the pixel of row (row-1-k) at column x.
    logic [BitSize-1:0]  line_mem [Channels][N-1][ImageWidth];

    window_t             win;
    window_t             win_next;
    column_t             col_vec;

    logic                accept;
    logic                consume;
    logic                emit;
    logic                last_hit;
    int                  col_off;
    int                  row_off;

    // Handshake: input is blocked only while a window sits unconsumed.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
        consume  = out_valid && out_ready;
    end

    // Decide whether the pixel being accepted completes a stride-aligned window.
    always_comb begin
        col_off  = int'(col) - (N - 1);
        row_off  = int'(row) - (N - 1);
        emit     = accept && (col_off >= 0) && (row_off >= 0) &&
                   ((col_off % Stride) == 0) && ((row_off % Stride) == 0);
        last_hit = (int'(row) == LastRow) && (int'(col) == LastCol);
    end

    // Build the incoming column (oldest row first) and the shifted window.
    always_comb begin
        col_vec  = '0;
        win_next = '0;
        for (int ch = 0; ch < Channels; ch++) begin
            col_vec[ch][N-1] = in_data[ch];
            for (int i = 0; i < N - 1; i++) begin
                col_vec[ch][i] = line_mem[ch][N-2-i][col];
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N - 1; j++) begin
                    win_next[ch][i][j] = win[ch][i][j+1];
                end
                win_next[ch][i][N-1] = col_vec[ch][i];
            end
        end
    end

    // Line buffers and window shifter; contents need no reset because
    // nothing is emitted until they have been refilled from the current frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int ch = 0; ch < Channels; ch++) begin
                line_mem[ch][0][col] <= in_data[ch];
                for (int k = 1; k < N - 1; k++) begin
                    line_mem[ch][k][col] <= line_mem[ch][k-1][col];
                end
            end
            win <= win_next;
        end
    end

    // Raster position of the next pixel to be accepted, wrapping per frame.
    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == ColMax) begin
                col <= '0;
                row <= (row == RowMax) ? '0 : row + RowW'(1);
            end else begin
                col <= col + ColW'(1);
            end
        end
    end

    // Output register: load a new window, or drop valid once consumed.
    always_ff @(posedge clk or posedge res_n) begin
        if (res_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_done  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= win_next;
                out_last  <= last_hit;
            end else if (consume) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            out_done <= consume && out_last;
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Testbench for conv_window_buffer.
// Two instances are exercised one at a time: dutA (N=3, 4x4, stride 1,
// one 8-bit channel) and dutB (N=3, 5 wide x 6 high, stride 2, two 4-bit
// channels). Every cycle the outputs are compared against a reference model
// that extracts windows straight from the frame array.
module tb_conv_window_buffer;

    localparam int N     = 3;
    localparam int AW    = 4;
    localparam int AH    = 4;
    localparam int AS    = 1;
    localparam int ABits = 8;
    localparam int BW    = 5;
    localparam int BH    = 6;
    localparam int BS    = 2;
    localparam int BBits = 4;

    logic clk = 1'b0;
    logic res_n;

    logic                                aInValid;
    logic                                aInReady;
    logic [0:0][ABits-1:0]               aInData;
    logic                                aOutValid;
    logic                                aOutReady;
    logic [0:0][N-1:0][N-1:0][ABits-1:0] aOutData;
    logic                                aOutLast;
    logic                                aOutDone;

    logic                                bInValid;
    logic                                bInReady;
    logic [1:0][BBits-1:0]               bInData;
    logic                                bOutValid;
    logic                                bOutReady;
    logic [1:0][N-1:0][N-1:0][BBits-1:0] bOutData;
    logic                                bOutLast;
    logic                                bOutDone;

    // Bookkeeping and reference-model state.
    int nChecks;
    int nFail;
    int which;
    int stream[$];
    int sp;
    int fstart;
    bit expValid;
    bit expLast;
    bit expDone;
    int expWin[2][N][N];
    bit obsValid;
    bit obsReady;
    bit obsLast;
    bit obsDone;
    int obsWin[2][N][N];
    int obsLog[$];
    int winCount;
    int doneCount;

    always #5 clk = ~clk;

    conv_window_buffer #(
        .N(N), .BitSize(ABits), .ImageWidth(AW), .ImageHeight(AH),
        .Channels(1), .Stride(AS)
    ) dutA (
        .clk(clk), .res_n(res_n),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .out_last(aOutLast), .out_done(aOutDone)
    );

    conv_window_buffer #(
        .N(N), .BitSize(BBits), .ImageWidth(BW), .ImageHeight(BH),
        .Channels(2), .Stride(BS)
    ) dutB (
        .clk(clk), .res_n(res_n),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .out_last(bOutLast), .out_done(bOutDone)
    );

    // Geometry of whichever instance is currently under test.
    function automatic int fw();
        return (which == 0) ? AW : BW;
    endfunction
    function automatic int fh();
        return (which == 0) ? AH : BH;
    endfunction
    function automatic int fs();
        return (which == 0) ? AS : BS;
    endfunction
    function automatic int fc();
        return (which == 0) ? 1 : 2;
    endfunction
    function automatic int fmask();
        return (which == 0) ? 255 : 15;
    endfunction

    // One comparison: counts it, and on a miss counts and reports it.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Compare the sampled window with the model window, tap by tap.
    task automatic checkWindow(input string tag);
        for (int ch = 0; ch < fc(); ch++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    checkOutput($sformatf("%s[%0d][%0d][%0d]", tag, ch, i, j),
                                obsWin[ch][i][j], expWin[ch][i][j]);
    endtask

    // Drive the active instance; the idle one sees no traffic.
    task automatic driveInputs(input bit v, input bit r, input int val);
        logic [7:0] v8;
        v8 = val[7:0];
        aInValid  = 1'b0;
        aOutReady = 1'b1;
        bInValid  = 1'b0;
        bOutReady = 1'b1;
        if (which == 0) begin
            aInValid   = v;
            aInData[0] = v8;
            aOutReady  = r;
        end else begin
            bInValid   = v;
            bInData[0] = v8[3:0];
            bInData[1] = 4'hF - v8[3:0];
            bOutReady  = r;
        end
    endtask

    // Snapshot the active instance's outputs.
    task automatic readOutputs();
        if (which == 0) begin
            obsValid = aOutValid;
            obsReady = aInReady;
            obsLast  = aOutLast;
            obsDone  = aOutDone;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    obsWin[0][i][j] = int'(aOutData[0][i][j]);
                    obsWin[1][i][j] = 0;
                end
        end else begin
            obsValid = bOutValid;
            obsReady = bInReady;
            obsLast  = bOutLast;
            obsDone  = bOutDone;
            for (int ch = 0; ch < 2; ch++)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        obsWin[ch][i][j] = int'(bOutData[ch][i][j]);
        end
    endtask

    // Forget any pending window in the model (after a reset).
    task automatic clearModel();
        expValid = 1'b0;
        expLast  = 1'b0;
        expDone  = 1'b0;
        for (int ch = 0; ch < 2; ch++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    expWin[ch][i][j] = 0;
    endtask

    // One clock cycle: drive at the falling edge, predict what the rising edge
    // does from the frame array, then sample and compare at the next falling edge.
    task automatic applyStimulus(input bit v, input bit r);
        bit have;
        bit fire;
        bit consume;
        bit emit;
        int val;
        int p;
        int rr;
        int cc;
        int m;
        have = v && (sp < stream.size());
        val  = have ? stream[sp] : 0;
        driveInputs(have, r, val);
        #1;
        readOutputs();
        checkOutput("in_ready", int'(obsReady), int'(!expValid || r));
        if (obsValid && r) begin
            winCount++;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    obsLog.push_back(obsWin[0][i][j]);
        end
        fire    = have && (!expValid || r);
        consume = expValid && r;
        expDone = consume && expLast;
        emit    = 1'b0;
        if (fire) begin
            p  = sp - fstart;
            rr = p / fw() - (N - 1);
            cc = p % fw() - (N - 1);
            if (rr >= 0 && cc >= 0 && (rr % fs()) == 0 && (cc % fs()) == 0) begin
                emit = 1'b1;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        m = stream[fstart + (rr + i) * fw() + cc + j] & fmask();
                        expWin[0][i][j] = m;
                        expWin[1][i][j] = (which == 0) ? 0 : 15 - m;
                    end
                expLast = (rr == ((fh() - N) / fs()) * fs()) &&
                          (cc == ((fw() - N) / fs()) * fs());
            end
            sp++;
            if (sp - fstart == fw() * fh())
                fstart = sp;
        end
        if (emit) begin
            expValid = 1'b1;
        end else if (consume) begin
            expValid = 1'b0;
            expLast  = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        readOutputs();
        checkOutput("out_valid", int'(obsValid), int'(expValid));
        checkOutput("out_last", int'(obsLast), int'(expLast));
        checkOutput("out_done", int'(obsDone), int'(expDone));
        if (obsDone)
            doneCount++;
        if (expValid)
            checkWindow("out_data");
    endtask

    // Fresh stream and fresh logs for the chosen instance.
    task automatic startScenario(input int w);
        which = w;
        sp = 0;
        fstart = 0;
        stream.delete();
        obsLog.delete();
        winCount = 0;
        doneCount = 0;
        driveInputs(1'b0, 1'b1, 0);
    endtask

    // Stream everything queued, then drain. Mode 0: full rate;
    // mode 1: five-cycle out_ready stall at the first window; mode 2: random.
    task automatic runFrame(input int mode);
        int hold;
        int idle;
        bit v;
        bit r;
        hold = 5;
        idle = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (sp >= stream.size() && !expValid) begin
                idle++;
                if (idle > 2)
                    break;
            end
            v = 1'b1;
            r = 1'b1;
            if (mode == 1 && expValid && hold > 0) begin
                r = 1'b0;
                hold--;
            end
            if (mode == 2) begin
                v = ($urandom_range(3) != 0);
                r = ($urandom_range(1) == 1);
            end
            applyStimulus(v, r);
        end
        checkOutput("drain_bound", int'(sp >= stream.size() && !expValid), 1);
    endtask

    // Check one logged window (channel 0, row-major) against a list.
    task automatic checkLogWin(input string tag, input int idx, input int e[9]);
        if (obsLog.size() < (idx + 1) * 9) begin
            checkOutput({tag, "_present"}, obsLog.size() / 9, idx + 1);
        end else begin
            for (int k = 0; k < 9; k++)
                checkOutput(tag, obsLog[idx * 9 + k], e[k]);
        end
    endtask

    // The four windows of a 4x4 frame holding 0..15, in raster order.
    task automatic checkBasicLog(input string tag, input int first);
        int e[9];
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    e[i * 3 + j] = (k / 2 + i) * 4 + (k % 2) + j;
            checkLogWin(tag, first + k, e);
        end
    endtask

    // Idle watchdog in case the clocked sequence ever stops advancing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of scenarios with model-checked random handshakes.
    initial begin
        int e9[9];
        int topLeft[4];
        nChecks = 0;
        nFail = 0;
        which = 0;
        res_n = 1'b1;
        aInData = '0;
        bInData = '0;
        driveInputs(1'b0, 1'b1, 0);
        which = 1;
        driveInputs(1'b0, 1'b1, 0);
        clearModel();

        // Reset state of both instances.
        @(negedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            which = w;
            readOutputs();
            checkOutput("reset_out_valid", int'(obsValid), 0);
            checkOutput("reset_out_last", int'(obsLast), 0);
            checkOutput("reset_out_done", int'(obsDone), 0);
            checkWindow("reset_out_data");
        end
        res_n = 1'b0;

        // Basic 4x4 frame, always ready.
        startScenario(0);
        for (int i = 0; i < 16; i++) stream.push_back(i);
        runFrame(0);
        checkOutput("basic_count", winCount, 4);
        checkOutput("basic_done", doneCount, 1);
        e9 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        checkLogWin("basic_first", 0, e9);
        e9 = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        checkLogWin("basic_last", 3, e9);

        // Five-cycle stall at the first window.
        startScenario(0);
        for (int i = 0; i < 16; i++) stream.push_back(i);
        runFrame(1);
        checkOutput("stall_count", winCount, 4);
        checkOutput("stall_done", doneCount, 1);
        checkBasicLog("stall_seq", 0);

        // Random in_valid gaps and out_ready toggling.
        startScenario(0);
        for (int i = 0; i < 16; i++) stream.push_back(i);
        runFrame(2);
        checkOutput("random_count", winCount, 4);
        checkOutput("random_done", doneCount, 1);
        checkBasicLog("random_seq", 0);

        // Two frames back to back; the second holds 16 - index.
        startScenario(0);
        for (int i = 0; i < 16; i++) stream.push_back(i);
        for (int i = 0; i < 16; i++) stream.push_back(16 - i);
        runFrame(0);
        checkOutput("b2b_count", winCount, 8);
        checkOutput("b2b_done", doneCount, 2);
        checkBasicLog("b2b_frame1", 0);
        e9 = '{16, 15, 14, 12, 11, 10, 8, 7, 6};
        checkLogWin("b2b_frame2_first", 4, e9);

        // Reset mid-frame with a window pending, then a fresh frame.
        startScenario(0);
        for (int i = 0; i < 16; i++) stream.push_back(i);
        for (int cyc = 0; cyc < 40 && sp < 11; cyc++)
            applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midreset_pending", int'(obsValid), 1);
        driveInputs(1'b0, 1'b1, 0);
        #2;
        res_n = 1'b1;
        #1;
        clearModel();
        readOutputs();
        checkOutput("midreset_out_valid", int'(obsValid), 0);
        checkOutput("midreset_out_last", int'(obsLast), 0);
        checkOutput("midreset_out_done", int'(obsDone), 0);
        checkWindow("midreset_out_data");
        @(negedge clk);
        res_n = 1'b0;
        startScenario(0);
        for (int i = 0; i < 16; i++) stream.push_back(i);
        runFrame(0);
        checkOutput("midreset_count", winCount, 4);
        checkOutput("midreset_done", doneCount, 1);
        checkBasicLog("midreset_seq", 0);

        // Stride 2, two channels, 5 wide x 6 high, always ready.
        topLeft = '{0, 2, 10, 12};
        startScenario(1);
        for (int i = 0; i < BW * BH; i++) stream.push_back(i);
        runFrame(0);
        checkOutput("stride_count", winCount, 4);
        checkOutput("stride_done", doneCount, 1);
        for (int k = 0; k < 4; k++)
            if (obsLog.size() >= (k + 1) * 9)
                checkOutput($sformatf("stride_topleft%0d", k), obsLog[k * 9], topLeft[k]);

        // Same geometry with random handshakes.
        startScenario(1);
        for (int i = 0; i < BW * BH; i++) stream.push_back(i);
        runFrame(2);
        checkOutput("stride_random_count", winCount, 4);
        checkOutput("stride_random_done", doneCount, 1);
        for (int k = 0; k < 4; k++)
            if (obsLog.size() >= (k + 1) * 9)
                checkOutput($sformatf("stride_random_topleft%0d", k), obsLog[k * 9], topLeft[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Parametrised successor to the single-channel convolution buffer. Accepts a raster-order pixel stream carrying all channels in parallel.
- Stores N-1 line buffers per channel and emits complete NxN windows for every channel at the configured stride.
- Sits between the image source (or a previous conv stage) and the convolution stage.
- Adds multi-channel input, non-square frames, stride, a true two-sided valid/ready handshake with backpressure, and back-to-back frames.

Parameters:
- N, 3: window edge length (N >= 2).
- BitSize, 4: bits per pixel per channel.
- ImageWidth, 4: pixels per row (>= N).
- ImageHeight, 4: rows per frame (>= N).
- Channels, 1: parallel channels per pixel.
- Stride, 1: window step in both directions (1 <= Stride <= N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res_n  in  1  reset, asynchronous, active-high (1 = reset asserted); the port keeps the codebase name.
- in_valid  in  1  in_data holds a valid pixel.
- in_ready  out  1  block accepts a pixel this cycle.
- in_data  in  [Channels-1:0][BitSize-1:0]  one pixel, all channels.
- out_valid  out  1  out_data holds a window.
- out_ready  in  1  downstream accepts the window.
- out_data  out  [Channels-1:0][N-1:0][N-1:0][BitSize-1:0]  window; [ch][i][j] = pixel (r+i, c+j).
- out_last  out  1  the current window is the final window of the frame.
- out_done  out  1  one-cycle pulse when the last window of the frame is handed off.

Behaviour:
- Reset (async assert, released on a clock edge):
  - out_valid = 0, out_last = 0, out_done = 0, out_data = 0.
  - Row and column counters = 0.
  - Line-buffer contents are don't-care; they are never read before being rewritten.
- Accept rule: a pixel is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - in_ready is 1 in the cycle after reset releases.
- Counters, advanced only on accept:
  - col counts 0..ImageWidth-1, then wraps to 0 and row increments.
  - row counts 0..ImageHeight-1, then wraps to 0, starting a new frame.
- Line buffers: each channel holds the last N-1 rows plus the current row's prefix. On accept, pixel (row, col) is written in place. No reads are issued from uninitialised rows.
- Window emission:
  - Window (r, c) is emitted when pixel (r+N-1, c+N-1) is accepted.
  - Condition: r % Stride == 0, c % Stride == 0, r <= ImageHeight-N, c <= ImageWidth-N.
  - out_valid rises the cycle after that accept (latency 1).
  - out_data is registered and holds stable while out_valid && !out_ready.
- Output handshake: a window is consumed when out_valid && out_ready.
  - If a new window completes in the same cycle one is consumed, out_valid stays 1 and out_data updates; there are no bubbles.
  - Otherwise out_valid falls to 0.
- Window count per frame: ((ImageHeight-N)/Stride+1) * ((ImageWidth-N)/Stride+1), integer division.
- out_last:
  - Asserted with the window where r = last stride-aligned row and c = last stride-aligned column.
  - Held with out_valid.
- out_done: 1 for exactly one cycle, registered, in the cycle after the last window is consumed.
- Trailing pixels: pixels that complete no window (e.g. columns beyond the last stride-aligned window) are accepted and stored; no output.
- Back-to-back frames: the first pixel of frame k+1 may be accepted in the cycle after the last pixel of frame k. Frame k+1 windows never mix with frame k data.
- Stall: while out_valid && !out_ready, in_ready = 0. No pixel is lost or duplicated.
- Reset mid-frame: all partial progress is discarded. Any pending window is dropped (out_valid = 0) and the next accepted pixel is (0, 0).
- Arithmetic: pure data movement; no width change on pixels.

Test Plan:
- Basic window: N=3, W=H=4, S=1, C=1, pixels 0..15 streamed continuously, out_ready=1.
  - 4 windows.
  - First appears one cycle after pixel 10 is accepted, with rows {0,1,2},{4,5,6},{8,9,10}.
  - Last is {5,6,7},{9,10,11},{13,14,15}, with out_last=1; out_done pulses once.
- Stride: N=3, W=H=5, S=2, pixels 0..24.
  - Exactly 4 windows, top-left pixels 0, 2, 10, 12.
  - No output after pixels 13 or 23.
- Backpressure: basic setup with out_ready held 0 for 5 cycles at the first window.
  - out_data is stable and in_ready=0 during the hold.
  - Output sequence is identical to the unstalled run.
  - Random out_ready toggling yields the same 4 windows in order.
- Multi-channel, non-square: C=2, W=5, H=3, ch0 = index, ch1 = 4'hF - index[3:0].
  - 3 windows; ch1 is the bitwise complement of ch0 in every tap.
- Back-to-back frames: two 4x4 frames with no gap; frame 2 pixels = 16 - index.
  - 8 windows total.
  - First frame-2 window is {16,15,14},{12,11,10},{8,7,6}.
  - out_done pulses twice.
- Reset mid-frame: assert res_n=1 asynchronously after pixel 9 is accepted, then stream a fresh 4x4 frame.
  - Outputs clear immediately.
  - Results are identical to the basic-window scenario.
